// File: rtl/j1_uart_io_pkg.sv
// j1_uart_io_pkg: register addresses, STAT bit indices and FSM state type for the j1 UART IO block
package j1_uart_io_pkg;
    localparam logic [15:0] UART_DATA_ADDR = 16'h1000;
    localparam logic [15:0] UART_STAT_ADDR = 16'h2000;
    localparam logic [15:0] UART_DIV_ADDR  = 16'h4000;
    localparam int STAT_RX_AVAIL = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_TX_IDLE  = 2;
    localparam int STAT_RX_OVR   = 3;
    localparam int STAT_RX_FERR  = 4;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT} uart_st_e;
endpackage

// File: rtl/j1_sync_fifo.sv
// j1_sync_fifo: synchronous show-ahead FIFO
//   clk, reset        clock, synchronous active-high reset
//   push_i, wdata_i   write request and data (accepted when not full, or when a pop frees a slot)
//   pop_i             pop request (ignored when empty)
//   rdata_o           head entry, 0 when empty
//   full_o, empty_o   occupancy flags
module j1_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_q [2**AW];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q[AW];
    assign rdata_o = empty_o ? '0 : mem_q[rp_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= wdata_i;
    end
endmodule

// File: rtl/j1_uart_io.sv
// j1_uart_io: j1 IO-bus responder serving an 8N1 UART with TX/RX FIFOs, status and baud divisor
//   clk, reset         clock, synchronous active-high reset
//   io_rd, io_wr       one-cycle read/write strobes from the core
//   io_addr, io_wdata  register address (full 16-bit match) and write data
//   io_rdata           combinational read data for io_addr
//   uart_rxd           asynchronous serial input, idle high
//   uart_txd           serial output, idle high
module j1_uart_io
    import j1_uart_io_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int BAUD    = 115200,
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    input  logic        uart_rxd,
    output logic        uart_txd
);
    localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD - 1);

    logic        sel_data, sel_stat, sel_div;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  tx_head, rx_head;
    logic [15:0] div_q, stat;

    uart_st_e    tx_st_q, tx_st_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        txd_q, txd_d, tx_end;

    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    uart_st_e    rx_st_q, rx_st_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [16:0] rx_half;
    logic        rx_end, rx_half_hit, fe_set;
    logic        ovr_q, ovr_d, fe_q, fe_d;

    assign sel_data = io_addr == UART_DATA_ADDR;
    assign sel_stat = io_addr == UART_STAT_ADDR;
    assign sel_div  = io_addr == UART_DIV_ADDR;
    assign tx_push  = io_wr && sel_data;
    assign rx_pop   = io_rd && sel_data;
    assign uart_txd = txd_q;

    j1_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .reset(reset), .push_i(tx_push), .pop_i(tx_pop), .wdata_i(io_wdata[7:0]),
        .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );

    j1_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .reset(reset), .push_i(rx_push), .pop_i(rx_pop), .wdata_i(rx_sh_q),
        .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
    );

    always_comb begin
        stat = '0;
        stat[STAT_RX_AVAIL] = !rx_empty;
        stat[STAT_TX_FULL]  = tx_full;
        stat[STAT_TX_IDLE]  = tx_empty && tx_st_q == ST_IDLE;
        stat[STAT_RX_OVR]   = ovr_q;
        stat[STAT_RX_FERR]  = fe_q;
        io_rdata = sel_data ? {8'h00, rx_head} : sel_stat ? stat : sel_div ? div_q : 16'h0000;
    end

    // Each bit lasts tx_div_q+1 clocks; the divisor is captured on entry to START.
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q + 16'd1;
        tx_div_d = tx_div_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_pop   = 1'b0;
        tx_end   = tx_cnt_q == tx_div_q;
        unique case (tx_st_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_st_d  = ST_START;
                    tx_pop   = 1'b1;
                    tx_sh_d  = tx_head;
                    tx_div_d = div_q;
                end
            end
            ST_START: if (tx_end) begin
                tx_st_d  = ST_DATA;
                tx_cnt_d = '0;
                tx_bit_d = '0;
            end
            ST_DATA: if (tx_end) begin
                tx_cnt_d = '0;
                tx_sh_d  = tx_sh_q >> 1;
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_st_d = ST_STOP;
            end
            ST_STOP: if (tx_end) begin
                tx_cnt_d = '0;
                tx_st_d  = tx_empty ? ST_IDLE : ST_START;
                tx_pop   = !tx_empty;
                tx_sh_d  = tx_head;
                tx_div_d = div_q;
            end
            default: tx_st_d = ST_IDLE;
        endcase
        txd_d = tx_st_d == ST_START ? 1'b0 : tx_st_d == ST_DATA ? tx_sh_d[0] : 1'b1;
    end

    // Start is re-checked half a bit in; data and stop are then sampled one bit period apart.
    always_comb begin
        rx_st_d     = rx_st_q;
        rx_cnt_d    = rx_cnt_q + 16'd1;
        rx_div_d    = rx_div_q;
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        rx_push     = 1'b0;
        fe_set      = 1'b0;
        rx_end      = rx_cnt_q == rx_div_q;
        rx_half     = ({1'b0, rx_div_q} + 17'd1) >> 1;
        rx_half_hit = ({1'b0, rx_cnt_q} + 17'd1) >= rx_half;
        unique case (rx_st_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (rx_s3_q && !rx_s2_q) begin
                    rx_st_d  = ST_START;
                    rx_div_d = div_q;
                end
            end
            ST_START: if (rx_half_hit) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_s2_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (rx_end) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = ST_STOP;
            end
            ST_STOP: if (rx_end) begin
                rx_cnt_d = '0;
                rx_push  = rx_s2_q;
                fe_set   = !rx_s2_q;
                rx_st_d  = rx_s2_q ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                rx_cnt_d = '0;
                if (rx_s2_q) rx_st_d = ST_IDLE;
            end
            default: rx_st_d = ST_IDLE;
        endcase
        ovr_d = (rx_push && rx_full && !rx_pop) || (ovr_q && !(io_wr && sel_stat && io_wdata[STAT_RX_OVR]));
        fe_d  = fe_set || (fe_q && !(io_wr && sel_stat && io_wdata[STAT_RX_FERR]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= DIV_RST;
            tx_st_q  <= ST_IDLE;
            tx_cnt_q <= '0;
            tx_div_q <= DIV_RST;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            txd_q    <= 1'b1;
            rx_s1_q  <= 1'b1;
            rx_s2_q  <= 1'b1;
            rx_s3_q  <= 1'b1;
            rx_st_q  <= ST_IDLE;
            rx_cnt_q <= '0;
            rx_div_q <= DIV_RST;
            rx_bit_q <= '0;
            rx_sh_q  <= '0;
            ovr_q    <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            if (io_wr && sel_div) div_q <= io_wdata;
            tx_st_q  <= tx_st_d;
            tx_cnt_q <= tx_cnt_d;
            tx_div_q <= tx_div_d;
            tx_bit_q <= tx_bit_d;
            tx_sh_q  <= tx_sh_d;
            txd_q    <= txd_d;
            rx_s1_q  <= uart_rxd;
            rx_s2_q  <= rx_s1_q;
            rx_s3_q  <= rx_s2_q;
            rx_st_q  <= rx_st_d;
            rx_cnt_q <= rx_cnt_d;
            rx_div_q <= rx_div_d;
            rx_bit_q <= rx_bit_d;
            rx_sh_q  <= rx_sh_d;
            ovr_q    <= ovr_d;
            fe_q     <= fe_d;
        end
    end
endmodule

// File: tb/tb_j1_uart_io.sv
// tb_j1_uart_io: scoreboard bench for j1_uart_io (TX frames decoded from uart_txd, RX bytes read back over the io bus)
module tb_j1_uart_io;
    localparam logic [15:0] A_DATA = 16'h1000;
    localparam logic [15:0] A_STAT = 16'h2000;
    localparam logic [15:0] A_DIV  = 16'h4000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] io_addr = '0;
    logic [15:0] io_wdata = '0;
    logic [15:0] io_rdata;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;

    int checks = 0;
    int failures = 0;
    int tb_div = 433;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic mon_busy = 1'b0;
    logic mon_abort = 1'b0;
    logic b2b = 1'b0;
    logic have_prev = 1'b0;
    int mcyc = 0;
    int prev_start = 0;

    j1_uart_io dut (
        .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic io_put(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        io_addr = a;
        io_wdata = d;
        io_wr = 1'b1;
    endtask

    task automatic io_idle();
        @(negedge clk);
        io_wr = 1'b0;
        io_addr = '0;
    endtask

    task automatic io_write(input logic [15:0] a, input logic [15:0] d);
        io_put(a, d);
        io_idle();
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        @(negedge clk);
        io_addr = a;
        io_rd = 1'b1;
        #1 d = io_rdata;
        check(tag, d, exp);
        @(negedge clk);
        io_rd = 1'b0;
        io_addr = '0;
    endtask

    task automatic rx_frame(input logic [7:0] v, input logic stop);
        int b = tb_div + 1;
        uart_rxd = 1'b0;
        repeat (b) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = v[i];
            repeat (b) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (b) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (b) @(negedge clk);
    endtask

    task automatic wait_tx(input int budget);
        int n = 0;
        while ((tx_q.size() != 0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("tx_drain_in_time", n < budget, 1);
        repeat (8) @(negedge clk);
    endtask

    task automatic mon_tick();
        @(negedge clk);
        mcyc++;
        if (reset) mon_abort = 1'b1;
    endtask

    initial begin
        int b;
        logic [7:0] v;
        logic stop;
        forever begin
            mon_tick();
            if (!reset && uart_txd === 1'b0) begin
                b = tb_div + 1;
                mon_busy = 1'b1;
                mon_abort = 1'b0;
                if (b2b && have_prev) check("tx_b2b_spacing", mcyc - prev_start, 10 * b);
                have_prev = 1'b1;
                prev_start = mcyc;
                repeat (b + b / 2) mon_tick();
                v[0] = uart_txd;
                for (int i = 1; i < 8; i++) begin
                    repeat (b) mon_tick();
                    v[i] = uart_txd;
                end
                repeat (b) mon_tick();
                stop = uart_txd;
                if (!mon_abort) begin
                    if (tx_q.size() == 0) check("tx_unexpected_frame", {24'h0, v}, 32'hFFFF_FFFF);
                    else check("tx_byte", v, tx_q.pop_front());
                    check("tx_stop_bit", stop, 1);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] a5 = 8'hA5;
        int n;
        int e;
        repeat (3) @(negedge clk);
        check("rst_txd", uart_txd, 1);
        reset = 1'b0;
        rd_chk("rst_stat", A_STAT, 16'h0004);
        rd_chk("rst_div", A_DIV, 16'd433);
        rd_chk("rst_data_empty", A_DATA, 16'h0000);
        rd_chk("unmapped_rd", 16'h3000, 16'h0000);
        io_write(16'h4001, 16'h1234);
        rd_chk("unmapped_wr", A_DIV, 16'd433);
        io_write(A_DIV, 16'd3);
        tb_div = 3;
        rd_chk("div_rw", A_DIV, 16'd3);

        tx_q.push_back(8'hA5);
        io_put(A_DATA, 16'h00A5);
        @(negedge clk);
        io_wr = 1'b0;
        io_addr = A_STAT;
        check("t1_pre_txd", uart_txd, 1);
        check("t1_pre_busy", io_rdata[2], 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            e = k < 4 ? 0 : k < 36 ? int'(a5[(k - 4) / 4]) : 1;
            check("t1_txd", uart_txd, e);
            check("t1_busy", io_rdata[2], 0);
        end
        @(negedge clk);
        check("t1_idle_stat", io_rdata, 16'h0004);
        io_addr = '0;
        wait_tx(200);

        have_prev = 1'b0;
        b2b = 1'b1;
        tx_q.push_back(8'hFF);
        io_put(A_DATA, 16'h00FF);
        for (int i = 0; i < 17; i++) begin
            io_put(A_DATA, 16'(i));
            if (i < 16) tx_q.push_back(8'(i));
        end
        io_idle();
        rd_chk("t2_full_stat", A_STAT, 16'h0002);
        wait_tx(3000);
        b2b = 1'b0;
        rd_chk("t2_idle_stat", A_STAT, 16'h0004);

        rx_q.push_back(8'h3C);
        rx_frame(8'h3C, 1'b1);
        rd_chk("t3_stat_avail", A_STAT, 16'h0005);
        rd_chk("t3_data", A_DATA, {8'h00, rx_q.pop_front()});
        rd_chk("t3_stat_empty", A_STAT, 16'h0004);

        for (int i = 0; i < 17; i++) begin
            rx_frame(8'h40 + 8'(i), 1'b1);
            if (i < 16) rx_q.push_back(8'h40 + 8'(i));
        end
        rd_chk("t4_stat_ovr", A_STAT, 16'h000D);
        io_write(A_STAT, 16'h0008);
        rd_chk("t4_stat_clr", A_STAT, 16'h0005);
        n = 0;
        while (rx_q.size() != 0 && n < 32) begin
            rd_chk("t4_data", A_DATA, {8'h00, rx_q.pop_front()});
            n++;
        end
        rd_chk("t4_stat_drained", A_STAT, 16'h0004);
        rd_chk("t4_data_empty", A_DATA, 16'h0000);

        rx_frame(8'h77, 1'b0);
        rd_chk("t5_stat_ferr", A_STAT, 16'h0014);
        rd_chk("t5_no_push", A_DATA, 16'h0000);
        io_write(A_STAT, 16'h0010);
        rd_chk("t5_stat_clr", A_STAT, 16'h0004);
        @(negedge clk);
        uart_rxd = 1'b0;
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (40) @(negedge clk);
        rd_chk("t5_glitch_stat", A_STAT, 16'h0004);
        rd_chk("t5_glitch_data", A_DATA, 16'h0000);

        io_write(A_DATA, 16'h005A);
        n = 0;
        while (uart_txd !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_frame_started", n < 20, 1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_txd_after_reset", uart_txd, 1);
        @(negedge clk);
        reset = 1'b0;
        tb_div = 433;
        rd_chk("t6_stat", A_STAT, 16'h0004);
        rd_chk("t6_div", A_DIV, 16'd433);
        repeat (10) @(negedge clk);
        check("t6_txd_idle", uart_txd, 1);
        check("tx_queue_empty", tx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
